// File: rtl/endgame_char_draw.sv
// Overlays the "GAME OVER" message (8x16 glyphs scaled 4x4) onto the end-game box; 3-stage pipeline.
// Optional text blinking is enabled by defining ENDGAME_TEXT_BLINK_EN.
module endgame_char_draw #(
   parameter int          H_MIN        = 448,
   parameter int          V_MIN        = 500,
   parameter int          TEXT_V_OFF   = 8,
   parameter logic [11:0] TEXT_RGB     = 12'hfff,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        i_pclk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [11:0] i_vcount,
   input  logic        i_vsync,
   input  logic        i_vblnk,
   input  logic [11:0] i_hcount,
   input  logic        i_hsync,
   input  logic        i_hblnk,
   input  logic [11:0] i_rgb,
   output logic [10:0] o_font_addr,
   input  logic [7:0]  i_font_data,
   output logic [11:0] o_vcount,
   output logic        o_vsync,
   output logic        o_vblnk,
   output logic [11:0] o_hcount,
   output logic        o_hsync,
   output logic        o_hblnk,
   output logic [11:0] o_rgb
);

   localparam logic [11:0] H_LO = 12'(H_MIN);
   localparam logic [11:0] H_HI = 12'(H_MIN + 1024);
   localparam logic [11:0] V_LO = 12'(V_MIN + TEXT_V_OFF);
   localparam logic [11:0] V_HI = 12'(V_MIN + TEXT_V_OFF + 64);

   function automatic logic [6:0] msg_code(input logic [4:0] idx);
      logic [6:0] c;
      case (idx)
         5'd11:   c = 7'h47;  // G
         5'd12:   c = 7'h41;  // A
         5'd13:   c = 7'h4d;  // M
         5'd14:   c = 7'h45;  // E
         5'd16:   c = 7'h4f;  // O
         5'd17:   c = 7'h56;  // V
         5'd18:   c = 7'h45;  // E
         5'd19:   c = 7'h52;  // R
         default: c = 7'h20;
      endcase
      return c;
   endfunction

   logic [11:0] x_off;
   logic [11:0] y_off;
   logic        in_txt;
   logic [10:0] font_addr_next;
   logic [9:0]  off_unused;

   logic        s1_en, s1_in_txt, s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
   logic [2:0]  s1_col;
   logic [11:0] s1_vcount, s1_hcount, s1_rgb;
   logic        s2_en, s2_in_txt, s2_vsync, s2_vblnk, s2_hsync, s2_hblnk;
   logic [2:0]  s2_col;
   logic [11:0] s2_vcount, s2_hcount, s2_rgb;
   logic        visible;
   logic        draw;

   // Stage-1 geometry: text-area membership and glyph ROM address
   always_comb begin
      x_off          = i_hcount - H_LO;
      y_off          = i_vcount - V_LO;
      in_txt         = !i_hblnk && !i_vblnk &&
                       (i_hcount >= H_LO) && (i_hcount < H_HI) &&
                       (i_vcount >= V_LO) && (i_vcount < V_HI);
      font_addr_next = {7'h20, 4'h0};
      if (in_txt) begin
         font_addr_next = {msg_code(x_off[9:5]), y_off[5:2]};
      end else begin
         font_addr_next = {7'h20, 4'h0};
      end
   end

   assign off_unused = {x_off[11:10], x_off[1:0], y_off[11:6]};

   // ROM data for the stage-2 pixel arrives during the stage-2 cycle
   always_comb begin
      draw = 1'b0;
      if (s2_en && s2_in_txt && visible) begin
         draw = i_font_data[3'd7 - s2_col];
      end else begin
         draw = 1'b0;
      end
   end

   // Three-stage pipeline carrying the pixel, its timing and its overlay context
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_font_addr <= 11'h000;
         s1_en       <= 1'b0;
         s1_in_txt   <= 1'b0;
         s1_col      <= 3'd0;
         s1_vcount   <= 12'h000;
         s1_vsync    <= 1'b0;
         s1_vblnk    <= 1'b0;
         s1_hcount   <= 12'h000;
         s1_hsync    <= 1'b0;
         s1_hblnk    <= 1'b0;
         s1_rgb      <= 12'h000;
         s2_en       <= 1'b0;
         s2_in_txt   <= 1'b0;
         s2_col      <= 3'd0;
         s2_vcount   <= 12'h000;
         s2_vsync    <= 1'b0;
         s2_vblnk    <= 1'b0;
         s2_hcount   <= 12'h000;
         s2_hsync    <= 1'b0;
         s2_hblnk    <= 1'b0;
         s2_rgb      <= 12'h000;
         o_vcount    <= 12'h000;
         o_vsync     <= 1'b0;
         o_vblnk     <= 1'b0;
         o_hcount    <= 12'h000;
         o_hsync     <= 1'b0;
         o_hblnk     <= 1'b0;
         o_rgb       <= 12'h000;
      end else begin
         o_font_addr <= font_addr_next;
         s1_en       <= i_en;
         s1_in_txt   <= in_txt;
         s1_col      <= x_off[4:2];
         s1_vcount   <= i_vcount;
         s1_vsync    <= i_vsync;
         s1_vblnk    <= i_vblnk;
         s1_hcount   <= i_hcount;
         s1_hsync    <= i_hsync;
         s1_hblnk    <= i_hblnk;
         s1_rgb      <= i_rgb;
         s2_en       <= s1_en;
         s2_in_txt   <= s1_in_txt;
         s2_col      <= s1_col;
         s2_vcount   <= s1_vcount;
         s2_vsync    <= s1_vsync;
         s2_vblnk    <= s1_vblnk;
         s2_hcount   <= s1_hcount;
         s2_hsync    <= s1_hsync;
         s2_hblnk    <= s1_hblnk;
         s2_rgb      <= s1_rgb;
         o_vcount    <= s2_vcount;
         o_vsync     <= s2_vsync;
         o_vblnk     <= s2_vblnk;
         o_hcount    <= s2_hcount;
         o_hsync     <= s2_hsync;
         o_hblnk     <= s2_hblnk;
         o_rgb       <= draw ? TEXT_RGB : s2_rgb;
      end
   end

`ifdef ENDGAME_TEXT_BLINK_EN
   localparam int             CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(BLINK_FRAMES - 1);

   logic          vblnk_d;
   logic [CW-1:0] frame_cnt;

   // Frame counter advances on vblank entry, so visibility never flips mid-frame
   always_ff @(posedge i_pclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vblnk_d   <= 1'b0;
         frame_cnt <= '0;
         visible   <= 1'b1;
      end else begin
         vblnk_d <= i_vblnk;
         if (i_vblnk && !vblnk_d) begin
            if (frame_cnt == LAST) begin
               frame_cnt <= '0;
               visible   <= !visible;
            end else begin
               frame_cnt <= frame_cnt + CW'(1);
            end
         end
      end
   end
`else
   logic blink_unused;
   assign blink_unused = (BLINK_FRAMES > 0);
   assign visible      = 1'b1;
`endif

endmodule
